// File: rtl/bubble_sipo_loader.sv
// -----------------------------------------------------------------------------
// bubble_sipo_loader
//
// Serial-in/parallel-out word assembler upstream of the DL latch bank in the
// bubble-data read path. Serial bits from the bubble detector are shifted in
// MSB first. Once a dw-bit word is complete it is presented on o_DATA, and
// o_LATCH_EN pulses for one enabled period to load the downstream DL.
//
// Every state change is qualified by the shared active-low clock enable
// i_CEN_n. When the enable is off, the block freezes completely, and that
// freeze includes the load strobe.
//
// Optional feature, macro BUBBLE_SIPO_PARITY_EN:
//   defined   - an even-parity bit follows each word (PAR state), and
//               o_PARITY_ERR reports a mismatch from LOAD until the next
//               accepted i_START.
//   undefined - no PAR state; o_PARITY_ERR is tied low.
// -----------------------------------------------------------------------------
module bubble_sipo_loader #(
    parameter int dw = 8
) (
    input  logic                      i_CLK,
    input  logic                      i_RST_n,
    input  logic                      i_CEN_n,
    input  logic                      i_START,
    input  logic                      i_SHIFT_EN,
    input  logic                      i_SDI,
    output logic [dw-1:0]             o_DATA,
    output logic                      o_LATCH_EN,
    output logic                      o_BUSY,
    output logic [$clog2(dw+1)-1:0]   o_BITCNT,
    output logic                      o_PARITY_ERR
);

    localparam int CW = $clog2(dw + 1);

    // Count value held just before the shift that completes the word.
    localparam logic [CW-1:0] LAST_BIT = CW'(dw - 1);

`ifdef BUBBLE_SIPO_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_PAR   = 2'd2,
        S_LOAD  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOAD  = 2'd3
    } state_t;
`endif

    state_t          state_q;
    logic [dw-1:0]   data_q;
    logic            latch_en_q;
    logic            busy_q;
    logic [CW-1:0]   bitcnt_q;
`ifdef BUBBLE_SIPO_PARITY_EN
    logic            par_err_q;
`endif

    // FSM, shift register, bit counter and registered outputs, all advanced
    // only on enabled edges.
    // NOTE: an asynchronous reset sits in the sensitivity list, and all state
    // is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            latch_en_q <= 1'b0;
            busy_q     <= 1'b0;
            bitcnt_q   <= '0;
`ifdef BUBBLE_SIPO_PARITY_EN
            par_err_q  <= 1'b0;
`endif
        end else if (!i_CEN_n) begin
            case (state_q)
                S_IDLE: begin
                    // Serial bits arriving before a START are not part of
                    // any word and are dropped.
                    if (i_START) begin
                        state_q  <= S_SHIFT;
                        busy_q   <= 1'b1;
                        bitcnt_q <= '0;
`ifdef BUBBLE_SIPO_PARITY_EN
                        par_err_q <= 1'b0;
`endif
                    end
                end

                S_SHIFT: begin
                    if (i_START) begin
                        // Restart. The partial word is abandoned without a
                        // strobe; o_DATA keeps its stale contents, which is
                        // harmless because the DL loads only on the strobe.
                        bitcnt_q <= '0;
                    end else if (i_SHIFT_EN) begin
                        data_q   <= {data_q[dw-2:0], i_SDI};
                        bitcnt_q <= bitcnt_q + 1'b1;
                        if (bitcnt_q == LAST_BIT) begin
`ifdef BUBBLE_SIPO_PARITY_EN
                            state_q    <= S_PAR;
`else
                            state_q    <= S_LOAD;
                            latch_en_q <= 1'b1;
`endif
                        end
                    end
                end

`ifdef BUBBLE_SIPO_PARITY_EN
                S_PAR: begin
                    if (i_START) begin
                        state_q  <= S_SHIFT;
                        bitcnt_q <= '0;
                    end else if (i_SHIFT_EN) begin
                        // The parity bit is only checked; it is not shifted
                        // into the word.
                        par_err_q  <= (^data_q) ^ i_SDI;
                        state_q    <= S_LOAD;
                        latch_en_q <= 1'b1;
                    end
                end
`endif

                S_LOAD: begin
                    // The strobe lasts exactly one enabled period. A START
                    // seen here chains straight into the next word.
                    latch_en_q <= 1'b0;
                    if (i_START) begin
                        state_q  <= S_SHIFT;
                        bitcnt_q <= '0;
`ifdef BUBBLE_SIPO_PARITY_EN
                        par_err_q <= 1'b0;
`endif
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q    <= S_IDLE;
                    latch_en_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    // Every output is driven straight from a register.
    assign o_DATA     = data_q;
    assign o_LATCH_EN = latch_en_q;
    assign o_BUSY     = busy_q;
    assign o_BITCNT   = bitcnt_q;
`ifdef BUBBLE_SIPO_PARITY_EN
    assign o_PARITY_ERR = par_err_q;
`else
    assign o_PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_bubble_sipo_loader.sv
// -----------------------------------------------------------------------------
// tb_bubble_sipo_loader
//
// Directed, self-checking bench for bubble_sipo_loader with dw=8. When
// BUBBLE_SIPO_PARITY_EN is defined, every word is followed by its even-parity
// bit, and the dedicated parity steps are included.
// -----------------------------------------------------------------------------
module tb_bubble_sipo_loader;

    localparam int DW = 8;
    localparam int BW = $clog2(DW + 1);
`ifdef BUBBLE_SIPO_PARITY_EN
    localparam int NB = DW + 1;   // serial bits per word, including parity
`else
    localparam int NB = DW;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cen_n = 1'b0;
    logic          start = 1'b0;
    logic          shift_en = 1'b0;
    logic          sdi = 1'b0;
    logic [DW-1:0] data;
    logic          latch_en;
    logic          busy;
    logic [BW-1:0] bitcnt;
    logic          par_err;

    int errors = 0;
    int checks = 0;

    bubble_sipo_loader #(.dw(DW)) dut (
        .i_CLK        (clk),
        .i_RST_n      (rst_n),
        .i_CEN_n      (cen_n),
        .i_START      (start),
        .i_SHIFT_EN   (shift_en),
        .i_SDI        (sdi),
        .o_DATA       (data),
        .o_LATCH_EN   (latch_en),
        .o_BUSY       (busy),
        .o_BITCNT     (bitcnt),
        .o_PARITY_ERR (par_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one raw clock; inputs change and outputs are sampled 1 ns
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serial bit i of a word: the data bits MSB first, then the even-parity
    // bit.
    function automatic logic bit_of(input logic [7:0] w, input int i);
        logic [7:0] t;
        t = w;
        if (i < 8) return t[3'(7 - i)];
        return ^t;
    endfunction

    // Shift in all NB serial bits of a word on consecutive enabled edges.
    // Returns the 1-based edge at which the strobe first rose (or -1) and
    // the number of edges on which the strobe was high.
    task automatic run_word(input logic [7:0] w, output int strobe_at, output int pulses);
        strobe_at = -1;
        pulses    = 0;
        for (int i = 0; i < NB; i++) begin
            cen_n = 1'b0; start = 1'b0; shift_en = 1'b1; sdi = bit_of(w, i);
            tick();
            if (latch_en) begin
                pulses++;
                if (strobe_at < 0) strobe_at = i + 1;
            end
        end
        shift_en = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_data"},   32'(data), 32'h0);
        check({tag, "_latch"},  32'(latch_en), 32'h0);
        check({tag, "_busy"},   32'(busy), 32'h0);
        check({tag, "_bitcnt"}, 32'(bitcnt), 32'h0);
        check({tag, "_perr"},   32'(par_err), 32'h0);
    endtask

    int strobe_at;
    int pulses;
    int first_strobe;

    initial begin
        // ---------------- Reset with random inputs ----------------
        for (int i = 0; i < 4; i++) begin
            cen_n = 1'($urandom); start = 1'($urandom);
            shift_en = 1'($urandom); sdi = 1'($urandom);
            tick();
        end
        check_cleared("reset");
        cen_n = 1'b0; start = 1'b0; shift_en = 1'b0; sdi = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_busy", 32'(busy), 32'h0);
            check("idle_latch", 32'(latch_en), 32'h0);
        end

        // ---------------- Nominal word 8'hA5 ----------------
        start = 1'b1;
        tick();
        check("nom_start_busy", 32'(busy), 32'h1);
        check("nom_start_cnt", 32'(bitcnt), 32'h0);
        run_word(8'hA5, strobe_at, pulses);
        check("nom_strobe_at", 32'(strobe_at), 32'(NB));
        check("nom_pulses", 32'(pulses), 32'h1);
        check("nom_data", 32'(data), 32'hA5);
        check("nom_cnt", 32'(bitcnt), 32'h8);
        check("nom_load_busy", 32'(busy), 32'h1);
        tick();
        check("nom_after_latch", 32'(latch_en), 32'h0);
        check("nom_after_busy", 32'(busy), 32'h0);
        check("nom_after_cnt", 32'(bitcnt), 32'h8);
        check("nom_after_data", 32'(data), 32'hA5);

        // ---------------- Enable gating ----------------
        cen_n = 1'b0; start = 1'b1; shift_en = 1'b0;
        tick();
        for (int i = 0; i < NB; i++) begin
            // Gated clock: START, SHIFT_EN and a wrong bit must all be ignored.
            cen_n = 1'b1; start = 1'b1; shift_en = 1'b1; sdi = ~bit_of(8'hA5, i);
            tick();
            check("gate_hold_cnt", 32'(bitcnt), 32'((i < DW) ? i : DW));
            // Enabled, no valid bit: hold.
            cen_n = 1'b0; start = 1'b0; shift_en = 1'b0;
            tick();
            check("gate_gap_cnt", 32'(bitcnt), 32'((i < DW) ? i : DW));
            // Enabled with a valid bit.
            shift_en = 1'b1; sdi = bit_of(8'hA5, i);
            tick();
            if (i == 3) check("gate_mid_data", 32'(data), 32'h5A);
        end
        check("gate_data", 32'(data), 32'hA5);
        check("gate_strobe", 32'(latch_en), 32'h1);
        cen_n = 1'b1; shift_en = 1'b0;
        tick();
        check("gate_strobe_held", 32'(latch_en), 32'h1);
        cen_n = 1'b0;
        tick();
        check("gate_strobe_end", 32'(latch_en), 32'h0);
        check("gate_idle_busy", 32'(busy), 32'h0);

        // ---------------- Abort after 3 bits, then 8'h3C ----------------
        start = 1'b1;
        tick();
        start = 1'b0; shift_en = 1'b1; sdi = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("abort_partial_data", 32'(data), 32'h2F);
        check("abort_partial_cnt", 32'(bitcnt), 32'h3);
        start = 1'b1; shift_en = 1'b1; sdi = 1'b1;
        tick();
        check("abort_restart_cnt", 32'(bitcnt), 32'h0);
        check("abort_restart_data", 32'(data), 32'h2F);
        check("abort_restart_latch", 32'(latch_en), 32'h0);
        run_word(8'h3C, strobe_at, pulses);
        check("abort_pulses", 32'(pulses), 32'h1);
        check("abort_strobe_at", 32'(strobe_at), 32'(NB));
        check("abort_data", 32'(data), 32'h3C);

        // ---------------- Back-to-back: START during LOAD, then 8'hC3 ----------
        start = 1'b1; shift_en = 1'b1; sdi = 1'b1;
        tick();
        check("b2b_latch_drop", 32'(latch_en), 32'h0);
        check("b2b_busy", 32'(busy), 32'h1);
        check("b2b_cnt", 32'(bitcnt), 32'h0);
        check("b2b_data_stable", 32'(data), 32'h3C);
        run_word(8'hC3, first_strobe, pulses);
        check("b2b_strobe_at", 32'(first_strobe), 32'(NB));
        check("b2b_pulses", 32'(pulses), 32'h1);
        check("b2b_data", 32'(data), 32'hC3);
        tick();
        check("b2b_idle_busy", 32'(busy), 32'h0);

        // ---------------- Reset mid-word ----------------
        start = 1'b1;
        tick();
        start = 1'b0; shift_en = 1'b1; sdi = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("mid_cnt", 32'(bitcnt), 32'h5);
        #2 rst_n = 1'b0;
        #1 check_cleared("mid_async");
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (latch_en) pulses++;
        end
        check("mid_no_strobe", 32'(pulses), 32'h0);
        check("mid_busy", 32'(busy), 32'h0);
        check("mid_cnt_after", 32'(bitcnt), 32'h0);
        shift_en = 1'b0;

`ifdef BUBBLE_SIPO_PARITY_EN
        // ---------------- Parity: good, then bad ----------------
        start = 1'b1;
        tick();
        start = 1'b0; shift_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sdi = bit_of(8'hA5, i);
            tick();
        end
        check("par_wait_latch", 32'(latch_en), 32'h0);
        check("par_wait_cnt", 32'(bitcnt), 32'h8);
        sdi = 1'b0;
        tick();
        check("par_good_latch", 32'(latch_en), 32'h1);
        check("par_good_err", 32'(par_err), 32'h0);
        check("par_good_data", 32'(data), 32'hA5);
        shift_en = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0; shift_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sdi = bit_of(8'hA5, i);
            tick();
        end
        sdi = 1'b1;
        tick();
        check("par_bad_latch", 32'(latch_en), 32'h1);
        check("par_bad_err", 32'(par_err), 32'h1);
        shift_en = 1'b0;
        tick();
        check("par_bad_err_held", 32'(par_err), 32'h1);
        start = 1'b1;
        tick();
        check("par_err_cleared", 32'(par_err), 32'h0);
        start = 1'b0;
`else
        // ---------------- No parity feature: flag stays low ----------------
        start = 1'b1;
        tick();
        run_word(8'h01, strobe_at, pulses);
        check("nopar_strobe", 32'(latch_en), 32'h1);
        check("nopar_err", 32'(par_err), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bubble_sipo_loader.md
Name: bubble_sipo_loader

Overview:
- Serial-in/parallel-out word assembler upstream of the DL latch bank in the bubble-data read path.
- Shifts serial bits from the bubble detector into a dw-bit word, MSB first.
- Presents the word on o_DATA and issues a single-period o_LATCH_EN strobe; the strobe drives the i_EN input of the downstream DL.
- Shares the DL clock and clock-enable scheme: every state change is qualified by i_CEN_n.

Parameters:
- dw, 8, word width in bits; legal range is 2 to 16.

Ports:
- i_CLK  input  1  system clock; all state updates on the rising edge.
- i_RST_n  input  1  asynchronous, active-low reset.
- i_CEN_n  input  1  active-low clock enable; when high, all state and outputs hold.
- i_START  input  1  begin (or restart) word assembly.
- i_SHIFT_EN  input  1  the current i_SDI bit is valid and is shifted in.
- i_SDI  input  1  serial data bit.
- o_DATA  output  dw  assembled word from the shift register; feeds DL i_D.
- o_LATCH_EN  output  1  one-period load strobe; feeds DL i_EN.
- o_BUSY  output  1  high while in SHIFT, PAR or LOAD.
- o_BITCNT  output  $clog2(dw+1)  number of data bits captured in the current word.
- o_PARITY_ERR  output  1  parity error flag for the last word.

Behaviour:
- Clock, enable and reset:
  - One clock. Reset is asynchronous and active-low.
  - Clock port is i_CLK, reset port is i_RST_n. Reset asserts immediately and releases synchronously at the next i_CLK edge.
  - An "enabled edge" is a rising edge of i_CLK with i_CEN_n=0. Inputs are sampled only on enabled edges.
- Reset values: state=IDLE, o_DATA=0, o_LATCH_EN=0, o_BUSY=0, o_BITCNT=0, o_PARITY_ERR=0.
- All outputs are registered. No combinational path from any input to any output.
- State machine: IDLE, SHIFT, PAR (present only with the optional feature), LOAD.
- IDLE:
  - i_START=1 -> SHIFT; o_BITCNT<=0; o_PARITY_ERR<=0.
  - i_SHIFT_EN is ignored.
- SHIFT:
  - i_START=1 has priority: restart with o_BITCNT<=0; the partial word is discarded and no strobe is issued. o_DATA is not cleared.
  - Otherwise, if i_SHIFT_EN=1: o_DATA<={o_DATA[dw-2:0],i_SDI}; o_BITCNT<=o_BITCNT+1.
  - On the shift that makes o_BITCNT=dw: go to PAR if the feature is enabled, else to LOAD and set o_LATCH_EN<=1 on the same edge.
  - If i_SHIFT_EN=0: hold everything.
- LOAD:
  - o_LATCH_EN=1 for exactly one enabled-edge period; o_DATA is stable throughout.
  - Next enabled edge: o_LATCH_EN<=0.
  - If i_START=1 on that edge -> SHIFT with o_BITCNT<=0 (back-to-back words, no idle gap); else -> IDLE.
  - i_SHIFT_EN is ignored in LOAD; a bit presented there is lost.
- Latency: the strobe asserts on the same enabled edge that captures the last data bit (no feature) or the parity bit (feature enabled).
- o_BITCNT:
  - Saturates at dw. It never wraps because the FSM leaves SHIFT at dw.
  - Holds its value through LOAD and IDLE until the next i_START.
- i_CEN_n=1 mid-word: complete freeze, including o_LATCH_EN. The strobe stays high for as many raw clocks as the enable is off.
- Reset mid-word or mid-LOAD: immediate return to reset values; no strobe is emitted.

Optional Feature:
- Macro BUBBLE_SIPO_PARITY_EN.
- Defined:
  - After dw data bits the FSM enters PAR.
  - The next i_SHIFT_EN=1 edge samples i_SDI as an even-parity bit; o_DATA is not shifted.
  - o_PARITY_ERR <= (^o_DATA) ^ i_SDI. Go to LOAD with o_LATCH_EN<=1.
  - o_PARITY_ERR is valid from LOAD onward and is cleared on the next accepted i_START.
  - i_START in PAR restarts, as in SHIFT.
- Undefined: the PAR state does not exist, and o_PARITY_ERR is tied to 0. The port is always present.

Test Plan:
- Reset: hold i_RST_n=0 with clock running and random inputs -> all outputs 0; release, then 3 idle edges -> o_BUSY=0, no strobe.
- Nominal word (dw=8): i_START, then 8 enabled shifts of 1,0,1,0,0,1,0,1 -> o_DATA=8'hA5, o_BITCNT=8, o_LATCH_EN high for exactly one enabled period, then IDLE.
- Enable gating: same word with i_CEN_n=1 on alternating clocks and i_SHIFT_EN=0 gaps -> o_DATA=8'hA5; o_LATCH_EN high for 2 raw clocks when a gated clock falls in LOAD.
- Abort and back-to-back: i_START after 3 bits, then 8 bits of 8'h3C -> o_DATA=8'h3C with a single strobe. i_START during LOAD, then 8 bits of 8'hC3 -> second strobe exactly 8 enabled edges after the first LOAD edge.
- Reset mid-word: assert i_RST_n=0 after 5 bits -> outputs clear asynchronously before the next clock edge; no strobe afterwards.
- Parity (BUBBLE_SIPO_PARITY_EN): 8'hA5 followed by parity bit 0 -> o_PARITY_ERR=0; same word with parity bit 1 -> o_PARITY_ERR=1 during LOAD, and 0 again after the next i_START.
